apb_cmd_bridge: RTL and testbench

//  Upstream command front-end for the APB register slave (pos 0x0, date 0x4, surname 0x8, name 0xC).
//  - Accepts read/write commands on a valid/ready request port and buffers them in a FIFO.
//  - Issues each command as a standards-compliant APB transfer (SETUP then ACCESS).
//  - Returns read data and error status on a valid/ready response port.
//  - Replaces task-driven bus access, so system logic can queue register traffic.

---
 rtl/apb_cmd_bridge.sv | 197 +++++++++++++++++++
 tb/tb_apb_cmd_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_bridge.sv
// Queued command front-end that issues valid/ready register commands as APB transfers.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_cmd_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
    begin : g_bad_cfg
        $error("apb_cmd_bridge: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES > 0");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    logic [EntW-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              full, empty, push, pop, head_avail;
    logic [EntW-1:0]   head;

    state_e            state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              done, done_err;
    logic [DATA_W-1:0] done_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = cmd_valid && !full;
    assign cmd_ready  = !full;
    // An empty FIFO forwards the command being pushed so IDLE can start on the accept edge.
    assign head       = empty ? {cmd_write, cmd_addr, cmd_wdata} : mem_q[rd_ptr_q];
    assign head_avail = !empty || push;

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;
        done_rdata  = '0;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (head_avail && !rsp_valid_q) begin
                    state_d  = StSetup;
                    psel_d   = 1'b1;
                    pwrite_d = head[EntW-1];
                    paddr_d  = head[EntW-2 -: ADDR_W];
                    pwdata_d = head[DATA_W-1:0];
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (PREADY) begin
                    done       = 1'b1;
                    done_err   = PSLVERR;
                    done_rdata = pwrite_q ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
                end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            pop         = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = done_err;
            rsp_rdata_d = done_rdata;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = StIdle;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Directed bench for apb_cmd_bridge with a small APB register slave (wait states, error, stall).
module tb_apb_cmd_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int total = 0;
    int bad = 0;

    logic [31:0] regs [4] = '{default: '0};
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic        stuck = 1'b0;
    logic        err_en = 1'b0;

    apb_cmd_bridge dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave: PREADY rises after wait_cfg ACCESS cycles; errors only at 0xC when enabled.
    assign PREADY  = PSEL && PENABLE && !stuck && (wcnt >= wait_cfg);
    assign PRDATA  = regs[PADDR[3:2]];
    assign PSLVERR = err_en && (PADDR == 32'hC);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) regs[PADDR[3:2]] <= PWDATA;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Presents a command and advances through its accept edge; cmd_valid is left high.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("send_ready_timeout", cmd_ready, 1);
        tick();
    endtask

    // Waits for a response (rsp_ready assumed 1), checks it, then steps past the drain edge.
    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, exp_err);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"}, PSEL, 0);
        check({tag, "_penable"}, PENABLE, 0);
        check({tag, "_pwrite"}, PWRITE, 0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pen;
        logic flag;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        #12;
        check_reset_outputs("rst");
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        tick();

        // 1: write 0x0=9 then read 0x0, zero-wait slave
        rsp_ready = 1'b1;
        send(1'b1, 32'h0, 32'd9);
        check("t1_e0_psel", PSEL, 1);
        check("t1_e0_penable", PENABLE, 0);
        check("t1_e0_pwrite", PWRITE, 1);
        check("t1_e0_pwdata", PWDATA, 9);
        send(1'b0, 32'h0, 32'h0);
        cmd_valid = 1'b0;
        check("t1_e1_psel", PSEL, 1);
        check("t1_e1_penable", PENABLE, 1);
        tick();
        check("t1_e2_psel", PSEL, 0);
        check("t1_e2_rsp_valid", rsp_valid, 1);
        check("t1_e2_rdata", rsp_rdata, 0);
        check("t1_e2_err", rsp_err, 0);
        tick();
        check("t1_e3_rsp_valid", rsp_valid, 0);
        check("t1_e3_psel", PSEL, 0);
        tick();
        check("t1_e4_psel", PSEL, 1);
        check("t1_e4_pwrite", PWRITE, 0);
        tick();
        check("t1_e5_penable", PENABLE, 1);
        tick();
        check("t1_e6_rsp_valid", rsp_valid, 1);
        check("t1_e6_rdata", rsp_rdata, 9);
        tick();
        check("t1_e7_rsp_valid", rsp_valid, 0);

        // 2: five commands with rsp_ready low; FIFO fills, response held
        rsp_ready = 1'b0;
        send(1'b1, 32'h4, 32'h11);
        send(1'b1, 32'hC, 32'h22);
        send(1'b0, 32'h4, 32'h0);
        send(1'b0, 32'hC, 32'h0);
        send(1'b1, 32'h8, 32'h33);
        cmd_valid = 1'b0;
        check("t2_full", cmd_ready, 0);
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!rsp_valid || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || PSEL) flag = 1'b0;
            tick();
        end
        check("t2_held", flag, 1);
        rsp_ready = 1'b1;
        wait_rsp("t2_c1", 32'h0, 1'b0);
        wait_rsp("t2_c2", 32'h0, 1'b0);
        wait_rsp("t2_c3", 32'h11, 1'b0);
        wait_rsp("t2_c4", 32'h22, 1'b0);
        wait_rsp("t2_c5", 32'h0, 1'b0);
        check("t2_ready_back", cmd_ready, 1);

        // 3: write 0x8 with 3 wait states
        wait_cfg = 3;
        send(1'b1, 32'h8, 32'h50616E66);
        cmd_valid = 1'b0;
        check("t3_setup", {PSEL, PENABLE}, 2'b10);
        tick();
        pen  = 0;
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (PENABLE) pen++;
            if (PADDR !== 32'h8 || PWDATA !== 32'h50616E66 || !PWRITE) flag = 1'b0;
            tick();
        end
        check("t3_penable_cycles", pen, 4);
        check("t3_stable", flag, 1);
        check("t3_done_penable", PENABLE, 0);
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_err", rsp_err, 0);
        wait_cfg = 0;
        tick();
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (PSEL || rsp_valid) flag = 1'b0;
            tick();
        end
        check("t3_single_pop", flag, 1);

        // 4: read 0xC errors, following read proceeds normally
        err_en = 1'b1;
        send(1'b0, 32'hC, 32'h0);
        send(1'b0, 32'h8, 32'h0);
        cmd_valid = 1'b0;
        wait_rsp("t4_err", 32'h22, 1'b1);
        wait_rsp("t4_next", 32'h50616E66, 1'b0);
        err_en = 1'b0;

        // 5: reset during ACCESS with two commands queued behind it
        stuck = 1'b1;
        send(1'b1, 32'h0, 32'hAA);
        send(1'b0, 32'h4, 32'h0);
        send(1'b0, 32'h8, 32'h0);
        cmd_valid = 1'b0;
        tick();
        check("t5_in_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick();
        stuck   = 1'b0;
        PRESETn = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (PSEL || rsp_valid || !cmd_ready) flag = 1'b0;
        end
        check("t5_flushed", flag, 1);
        send(1'b0, 32'h0, 32'h0);
        cmd_valid = 1'b0;
        wait_rsp("t5_reg0_kept", 32'd9, 1'b0);

        // 6: slave never ready
        stuck = 1'b1;
        send(1'b0, 32'h4, 32'h0);
        cmd_valid = 1'b0;
        check("t6_setup", {PSEL, PENABLE}, 2'b10);
        pen = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (PENABLE) pen++;
        end
        check("t6_access_cycles", pen, 16);
        tick();
`ifdef APB_TIMEOUT_EN
        check("t6_abort_penable", PENABLE, 0);
        check("t6_abort_psel", PSEL, 0);
        check("t6_abort_valid", rsp_valid, 1);
        check("t6_abort_err", rsp_err, 1);
        check("t6_abort_rdata", rsp_rdata, 0);
        stuck = 1'b0;
        tick();
        check("t6_drained", rsp_valid, 0);
`else
        check("t6_still_waiting", PENABLE, 1);
        check("t6_no_rsp", rsp_valid, 0);
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!PENABLE || rsp_valid) flag = 1'b0;
        end
        check("t6_waits_forever", flag, 1);
        stuck = 1'b0;
        wait_rsp("t6_late", 32'h11, 1'b0);
`endif

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
